audio_sample_fifo: RTL

//  Downstream of the SD-card block loader: accepts 16-bit words from its RAM-style write port
//  (ram_we / ram_address / ram_data, acked by ram_op_begun) into an on-chip ring buffer.

---
 rtl/audio_sample_fifo.sv | 131 +++++++++++++
 1 files changed

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Ring buffer between the SD-card block loader and the audio output path.
//   The loader pushes 16-bit words through a RAM-style write port. One sample is
//   released per sample_tick once the buffer has prefilled. The loader is held
//   off while the buffer is full, and silence is emitted on underrun.
// Ports
//   clk50, reset_n                  clock, asynchronous active-low reset
//   ram_we/ram_address/ram_data     loader write request (held until acked)
//   ram_op_begun                    write accepted this cycle (combinational)
//   ram_init_done                   loader finished the whole range
//   play_en, sample_tick            playback enable, sample-rate strobe
//   sample_o, sample_valid          registered sample, 1-cycle update pulse
//   fill_level                      words stored, 0..2**ADDR_W
//   underrun, seq_error             sticky error flags
//   playback_done                   stream finished and buffer drained
module audio_sample_fifo #(
  parameter int ADDR_W      = 10,
  parameter int START_LEVEL = 512
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              ram_we,
  input  logic [24:0]       ram_address,
  input  logic [15:0]       ram_data,
  output logic              ram_op_begun,
  input  logic              ram_init_done,
  input  logic              play_en,
  input  logic              sample_tick,
  output logic [15:0]       sample_o,
  output logic              sample_valid,
  output logic [ADDR_W:0]   fill_level,
  output logic              underrun,
  output logic              seq_error,
  output logic              playback_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] START_LVL = (ADDR_W + 1)'(START_LEVEL);

  typedef enum logic [1:0] {FILL, PLAY, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [24:0]       exp_addr;
  logic              full, empty, push, pop, tick_live, underrun_evt;

  assign full  = (fill_level == DEPTH_LVL);
  assign empty = (fill_level == '0);

  // No acceptance while reset is held, so the loader never sees an ack that
  // the cleared pointers would then forget.
  assign push         = ram_we & ~full & reset_n;
  assign ram_op_begun = push;

  assign tick_live    = (state_q == PLAY) & play_en & sample_tick;
  assign pop          = tick_live & ~empty;
  assign underrun_evt = tick_live & empty & ~ram_init_done;

  assign playback_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (fill_level >= START_LVL)
          state_d = PLAY;
        else if (ram_init_done)
          state_d = empty ? DONE : PLAY;
      end
      PLAY: begin
        if (ram_init_done & empty & ~push)
          state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk50) begin
    if (push)
      mem[wr_ptr] <= ram_data;
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      exp_addr     <= '0;
      sample_o     <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_valid <= pop;

      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        exp_addr <= exp_addr + 25'd1;
        if (ram_address != exp_addr)
          seq_error <= 1'b1;
      end

      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase

      // Keyed on the next state so sample_o is already silent on the first DONE cycle.
      if (state_d == DONE)
        sample_o <= '0;
      else if (pop)
        sample_o <= mem[rd_ptr];
      else if (underrun_evt)
        sample_o <= '0;

      if (underrun_evt)
        underrun <= 1'b1;
    end
  end

endmodule
